// File: rtl/fb_pkg.sv
// Shared widths, default screen geometry and types for the framebuffer write arbiter.
package fb_pkg;
  localparam int X_W          = 11;
  localparam int Y_W          = 11;
  localparam int PAL_W        = 2;
  localparam int H_ACTIVE_DEF = 800;
  localparam int V_ACTIVE_DEF = 600;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } fb_arb_state_t;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [PAL_W-1:0] palette;
  } fb_pixel_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);
  logic found;
  int   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end
endmodule

// File: rtl/fb_write_arbiter.sv
// Shares the framebuffer write port among NUM_REQ producers and runs a full-screen clear.
// Handshake: a pixel transfers when req_valid[i] & req_ready[i]; a requester holds valid/data until ready.
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic                     clk_33m,
  input  logic                     rst,
  input  logic                     clear_req,
  input  logic [PAL_W-1:0]         clear_palette,
  output logic                     clear_busy,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*X_W-1:0]   req_x,
  input  logic [NUM_REQ*Y_W-1:0]   req_y,
  input  logic [NUM_REQ*PAL_W-1:0] req_palette,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [X_W-1:0]           write_x,
  output logic [Y_W-1:0]           write_y,
  output logic [PAL_W-1:0]         write_palette,
  output logic                     write_en,
  output logic                     drop_pulse,
  output logic                     dbg_state
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  fb_arb_state_t    state_q, state_d;
  logic [X_W-1:0]   cx_q, cx_d;
  logic [Y_W-1:0]   cy_q, cy_d;
  logic [PAL_W-1:0] clr_pal_q, clr_pal_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  fb_pixel_t        out_q, out_d;
  logic             wen_q, wen_d;
  logic             drop_q, drop_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  fb_pixel_t          sel_pix;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_pix.x       = req_x[int'(grant_idx)*X_W +: X_W];
    sel_pix.y       = req_y[int'(grant_idx)*Y_W +: Y_W];
    sel_pix.palette = req_palette[int'(grant_idx)*PAL_W +: PAL_W];
  end

  always_comb begin
    state_d   = state_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    clr_pal_d = clr_pal_q;
    ptr_d     = ptr_q;
    out_d     = out_q;
    wen_d     = 1'b0;
    drop_d    = 1'b0;
    req_ready = '0;
    case (state_q)
      ARB: begin
        if (clear_req) begin
          // Clear wins over any pending requester; they stay stalled and are served afterwards.
          state_d   = CLEAR;
          cx_d      = '0;
          cy_d      = '0;
          clr_pal_d = clear_palette;
        end else begin
          req_ready = grant;
          if (|grant) begin
            ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            if ((sel_pix.x < X_W'(H_ACTIVE)) && (sel_pix.y < Y_W'(V_ACTIVE))) begin
              out_d = sel_pix;
              wen_d = 1'b1;
            end else begin
              drop_d = 1'b1;
            end
          end
        end
      end
      CLEAR: begin
        out_d.x       = cx_q;
        out_d.y       = cy_q;
        out_d.palette = clr_pal_q;
        wen_d         = 1'b1;
        if (cx_q == X_W'(H_ACTIVE - 1)) begin
          cx_d = '0;
          if (cy_q == Y_W'(V_ACTIVE - 1)) begin
            cy_d    = '0;
            state_d = ARB;
          end else begin
            cy_d = cy_q + 1'b1;
          end
        end else begin
          cx_d = cx_q + 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk_33m) begin
    if (rst) begin
      state_q   <= ARB;
      cx_q      <= '0;
      cy_q      <= '0;
      clr_pal_q <= '0;
      ptr_q     <= '0;
      out_q     <= '0;
      wen_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      clr_pal_q <= clr_pal_d;
      ptr_q     <= ptr_d;
      out_q     <= out_d;
      wen_q     <= wen_d;
      drop_q    <= drop_d;
    end
  end

  assign clear_busy    = (state_q == CLEAR);
  assign write_x       = out_q.x;
  assign write_y       = out_q.y;
  assign write_palette = out_q.palette;
  assign write_en      = wen_q;
  assign drop_pulse    = drop_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter on a 4x3 screen with two requesters.
module tb_fb_write_arbiter;
  import fb_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int H_ACT   = 4;
  localparam int V_ACT   = 3;

  logic                     clk_33m = 1'b0;
  logic                     rst;
  logic                     clear_req;
  logic [PAL_W-1:0]         clear_palette;
  logic                     clear_busy;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*X_W-1:0]   req_x;
  logic [NUM_REQ*Y_W-1:0]   req_y;
  logic [NUM_REQ*PAL_W-1:0] req_palette;
  logic [NUM_REQ-1:0]       req_ready;
  logic [X_W-1:0]           write_x;
  logic [Y_W-1:0]           write_y;
  logic [PAL_W-1:0]         write_palette;
  logic                     write_en;
  logic                     drop_pulse;
  logic                     dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  fb_write_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .H_ACTIVE (H_ACT),
    .V_ACTIVE (V_ACT)
  ) dut (
    .clk_33m       (clk_33m),
    .rst           (rst),
    .clear_req     (clear_req),
    .clear_palette (clear_palette),
    .clear_busy    (clear_busy),
    .req_valid     (req_valid),
    .req_x         (req_x),
    .req_y         (req_y),
    .req_palette   (req_palette),
    .req_ready     (req_ready),
    .write_x       (write_x),
    .write_y       (write_y),
    .write_palette (write_palette),
    .write_en      (write_en),
    .drop_pulse    (drop_pulse),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  always #5 clk_33m = ~clk_33m;

  task automatic tick();
    @(posedge clk_33m);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic set_req(input int i, input int x, input int y, input int pal);
    req_x[i*X_W +: X_W]         = X_W'(x);
    req_y[i*Y_W +: Y_W]         = Y_W'(y);
    req_palette[i*PAL_W +: PAL_W] = PAL_W'(pal);
  endtask

  task automatic check_pix(input string tag, input int x, input int y, input int pal, input int en);
    check({tag, ".x"},   32'(write_x),       32'(x));
    check({tag, ".y"},   32'(write_y),       32'(y));
    check({tag, ".pal"}, 32'(write_palette), 32'(pal));
    check({tag, ".en"},  32'(write_en),      32'(en));
  endtask

  initial begin
    rst = 1'b1; clear_req = 1'b0; clear_palette = '0;
    req_valid = '0; req_x = '0; req_y = '0; req_palette = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check_pix("reset", 0, 0, 0, 0);
    check("reset.drop",  32'(drop_pulse), 0);
    check("reset.busy",  32'(clear_busy), 0);
    check("reset.ready", 32'(req_ready),  0);
    check("reset.state", 32'(dbg_state),  0);

    // single requester, ptr=0
    set_req(0, 1, 2, 3);
    req_valid = 2'b01;
    #1 check("single.ready", 32'(req_ready), 32'b01);
    tick();
    req_valid = '0;
    check_pix("single", 1, 2, 3, 1);
    check("single.drop", 32'(drop_pulse), 0);

    // out-of-range from req1 (ptr now 1), returns ptr to 0
    set_req(1, 4, 0, 1);
    req_valid = 2'b10;
    #1 check("oor.ready", 32'(req_ready), 32'b10);
    tick();
    req_valid = '0;
    check_pix("oor", 1, 2, 3, 0);
    check("oor.drop", 32'(drop_pulse), 1);
    tick();
    check("oor.drop_clr", 32'(drop_pulse), 0);

    // fairness: both valid for 6 cycles
    set_req(0, 0, 0, 1);
    set_req(1, 3, 2, 2);
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      #1 check("fair.ready", 32'(req_ready), (i % 2 == 0) ? 32'b01 : 32'b10);
      tick();
      if (i % 2 == 0) check_pix("fair", 0, 0, 1, 1);
      else            check_pix("fair", 3, 2, 2, 1);
    end
    req_valid = '0;
    // idle hold
    for (int i = 0; i < 3; i++) begin
      tick();
      check_pix("idle1", 3, 2, 2, 0);
    end

    // clear with collision; req0 held throughout
    set_req(0, 2, 1, 3);
    req_valid = 2'b11;
    clear_req = 1'b1;
    clear_palette = 2'd2;
    #1 check("clr.collide_ready", 32'(req_ready), 0);
    tick();                                   // t+1
    clear_req = 1'b0;
    req_valid = 2'b01;
    #1;
    check("clr.busy_t1",  32'(clear_busy), 1);
    check("clr.ready_t1", 32'(req_ready),  0);
    check("clr.en_t1",    32'(write_en),   0);
    for (int k = 2; k <= 13; k++) begin
      tick();                                 // t+k
      if (k == 3) begin
        clear_req = 1'b1;
        clear_palette = 2'd1;
      end else begin
        clear_req = 1'b0;
      end
      #1;
      check_pix("clr", (k - 2) % H_ACT, (k - 2) / H_ACT, 2, 1);
      check("clr.busy",  32'(clear_busy), (k <= 12) ? 1 : 0);
      check("clr.ready", 32'(req_ready),  (k <= 12) ? 0 : 32'b01);
    end
    tick();                                   // t+14: held req0 written
    req_valid = '0;
    check_pix("post_clr", 2, 1, 3, 1);
    check("post_clr.busy", 32'(clear_busy), 0);

    // reset in the middle of a clear (ptr is now 1)
    clear_req = 1'b1;
    clear_palette = 2'd3;
    tick();                                   // t+1
    clear_req = 1'b0;
    for (int k = 2; k <= 7; k++) tick();      // t+7 shows pixel 5
    check_pix("abort.pix5", 1, 1, 3, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_pix("abort", 0, 0, 0, 0);
    check("abort.drop",  32'(drop_pulse), 0);
    check("abort.busy",  32'(clear_busy), 0);
    check("abort.state", 32'(dbg_state),  0);
    req_valid = 2'b11;
    set_req(0, 1, 1, 2);
    #1 check("abort.ptr_ready", 32'(req_ready), 32'b01);
    tick();
    req_valid = '0;
    check_pix("abort.req", 1, 1, 2, 1);
    tick();
    check("abort.clear_stays_off", 32'(write_en), 0);

    // idle: outputs hold indefinitely
    for (int i = 0; i < 5; i++) begin
      tick();
      check_pix("idle2", 1, 1, 2, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
